// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI pins plus rx/tx byte handshake of spi_slave.
// Ports: SPI mode-0 pins (i_spi_clk, i_cs, i_spi_mosi, o_spi_miso, o_spi_miso_oe),
// rx byte stream (o_rx_data, o_rx_valid, o_rx_first), tx holding buffer
// (i_tx_data, i_tx_valid, o_tx_ready, o_tx_underrun) and status (o_frame_abort, o_busy).
interface spi_slave_if;
    logic       i_spi_clk;
    logic       i_cs;
    logic       i_spi_mosi;
    logic       o_spi_miso;
    logic       o_spi_miso_oe;
    logic [7:0] o_rx_data;
    logic       o_rx_valid;
    logic       o_rx_first;
    logic [7:0] i_tx_data;
    logic       i_tx_valid;
    logic       o_tx_ready;
    logic       o_tx_underrun;
    logic       o_frame_abort;
    logic       o_busy;

    modport slave (
        input  i_spi_clk, i_cs, i_spi_mosi, i_tx_data, i_tx_valid,
        output o_spi_miso, o_spi_miso_oe, o_rx_data, o_rx_valid, o_rx_first,
               o_tx_ready, o_tx_underrun, o_frame_abort, o_busy
    );

    modport master (
        output i_spi_clk, i_cs, i_spi_mosi, i_tx_data, i_tx_valid,
        input  o_spi_miso, o_spi_miso_oe, o_rx_data, o_rx_valid, o_rx_first,
               o_tx_ready, o_tx_underrun, o_frame_abort, o_busy
    );
endinterface

// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 slave oversampled by i_clk, with one-byte tx holding buffer.
// Ports: i_clk (system clock), i_rst (sync active-high reset), bus (spi_slave_if.slave:
// SPI pins, rx byte output with first-byte flag, tx buffer write handshake, status pulses).
module spi_slave #(
    parameter int         P_SYNC_STAGES = 2,
    parameter logic [7:0] P_IDLE_MISO   = 8'hFF
) (
    input logic        i_clk,
    input logic        i_rst,
    spi_slave_if.slave bus
);
    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state, state_nxt;
    logic [P_SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
    logic       sck_d, cs_d;
    logic       sck_s, cs_s, mosi_s;
    logic       active, cs_assert, cs_deassert, start, rise, fall, load, wr;
    logic [2:0] bit_cnt;
    logic [6:0] rx_shift;
    logic [7:0] tx_shift, tx_buf, rx_data;
    logic       tx_full, first, byte_done;
    logic       rx_valid, rx_first, underrun, abort;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sck_d     <= 1'b0;
            cs_d      <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[P_SYNC_STAGES-2:0], bus.i_spi_clk};
            cs_sync   <= {cs_sync[P_SYNC_STAGES-2:0], bus.i_cs};
            mosi_sync <= {mosi_sync[P_SYNC_STAGES-2:0], bus.i_spi_mosi};
            sck_d     <= sck_s;
            cs_d      <= cs_s;
        end
    end

    assign sck_s       = sck_sync[P_SYNC_STAGES-1];
    assign cs_s        = cs_sync[P_SYNC_STAGES-1];
    assign mosi_s      = mosi_sync[P_SYNC_STAGES-1];
    assign active      = state == ACTIVE;
    assign cs_assert   = ~cs_s & cs_d;
    assign cs_deassert = cs_s & ~cs_d;
    assign start       = ~active & cs_assert;
    // A CS release suppresses any SCK edge seen in the same cycle, so a master
    // that drops SCK together with CS does not trigger a trailing tx load.
    assign rise        = active & ~cs_deassert & sck_s & ~sck_d;
    assign fall        = active & ~cs_deassert & ~sck_s & sck_d;
    assign load        = start | (fall & bit_cnt == 3'd0 & byte_done);
    assign wr          = bus.i_tx_valid & ~tx_full;

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = (~active & cs_assert) ? ACTIVE :
                    (active & cs_deassert) ? IDLE : state;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bit_cnt   <= '0;
            rx_shift  <= '0;
            tx_shift  <= '0;
            tx_buf    <= '0;
            rx_data   <= '0;
            tx_full   <= 1'b0;
            first     <= 1'b0;
            byte_done <= 1'b0;
            rx_valid  <= 1'b0;
            rx_first  <= 1'b0;
            underrun  <= 1'b0;
            abort     <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            underrun <= 1'b0;
            abort    <= 1'b0;
            if (start) begin
                bit_cnt   <= '0;
                first     <= 1'b1;
                byte_done <= 1'b0;
            end
            if (active && cs_deassert) begin
                bit_cnt <= '0;
                abort   <= bit_cnt != 3'd0;
            end
            if (rise) begin
                rx_shift <= {rx_shift[5:0], mosi_s};
                bit_cnt  <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    rx_data   <= {rx_shift, mosi_s};
                    rx_valid  <= 1'b1;
                    rx_first  <= first;
                    first     <= 1'b0;
                    byte_done <= 1'b1;
                end
            end
            if (load) begin
                tx_shift <= tx_full ? tx_buf : P_IDLE_MISO;
                underrun <= ~tx_full;
            end else if (fall) begin
                tx_shift <= {tx_shift[6:0], 1'b0};
            end
            // A write can only target an empty buffer, so a same-cycle load
            // always reports underrun and never bypasses the incoming byte.
            if (wr) begin
                tx_buf  <= bus.i_tx_data;
                tx_full <= 1'b1;
            end else if (load) begin
                tx_full <= 1'b0;
            end
        end
    end

    assign bus.o_spi_miso    = tx_shift[7];
    assign bus.o_spi_miso_oe = ~cs_s;
    assign bus.o_rx_data     = rx_data;
    assign bus.o_rx_valid    = rx_valid;
    assign bus.o_rx_first    = rx_first;
    assign bus.o_tx_ready    = ~tx_full;
    assign bus.o_tx_underrun = underrun;
    assign bus.o_frame_abort = abort;
    assign bus.o_busy        = active;
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: scoreboard bench for spi_slave driving a mode-0 SPI master at i_clk/8.
module tb_spi_slave;
    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    always #5 i_clk = ~i_clk;

    spi_slave_if bus();
    spi_slave dut (.i_clk(i_clk), .i_rst(i_rst), .bus(bus.slave));

    int checks = 0, errors = 0, n_rx = 0, n_und = 0, n_abort = 0;
    logic [8:0]  exp_q[$];
    logic [8:0]  exp_e;
    logic [15:0] m;

    function automatic logic [15:0] outs();
        return {bus.o_spi_miso, bus.o_spi_miso_oe, bus.o_rx_data, bus.o_rx_valid, bus.o_rx_first,
                bus.o_tx_ready, bus.o_tx_underrun, bus.o_frame_abort, bus.o_busy};
    endfunction

    always @(negedge i_clk) begin
        if (bus.o_rx_valid === 1'b1) begin
            n_rx++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rx_unexpected: got first=%0b data=%02h, required no byte", bus.o_rx_first, bus.o_rx_data);
            end else begin
                exp_e = exp_q.pop_front();
                if ({bus.o_rx_first, bus.o_rx_data} !== exp_e) begin
                    errors++;
                    $display("FAIL rx_byte: got first=%0b data=%02h, required first=%0b data=%02h",
                             bus.o_rx_first, bus.o_rx_data, exp_e[8], exp_e[7:0]);
                end
            end
        end
        if (bus.o_tx_underrun === 1'b1) n_und++;
        if (bus.o_frame_abort === 1'b1) n_abort++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic tx_write(input logic [7:0] d);
        @(negedge i_clk);
        bus.i_tx_data  = d;
        bus.i_tx_valid = 1'b1;
        @(negedge i_clk);
        bus.i_tx_valid = 1'b0;
    endtask

    task automatic spi_frame(input int nbits, input logic [15:0] mosi_w, input bit keep_cs,
                             output logic [15:0] miso_w);
        miso_w = '0;
        @(negedge i_clk);
        bus.i_cs = 1'b0;
        repeat (6) @(negedge i_clk);
        for (int b = nbits - 1; b >= 0; b--) begin
            bus.i_spi_mosi = mosi_w[b];
            repeat (4) @(negedge i_clk);
            miso_w[b] = bus.o_spi_miso;
            bus.i_spi_clk = 1'b1;
            repeat (4) @(negedge i_clk);
            if (b != 0) bus.i_spi_clk = 1'b0;
        end
        if (!keep_cs) begin
            bus.i_spi_clk = 1'b0;
            bus.i_cs      = 1'b1;
            repeat (8) @(negedge i_clk);
        end
    endtask

    task automatic test_reset();
        bus.i_cs = 1'b1;
        bus.i_spi_clk = 1'b0;
        bus.i_spi_mosi = 1'b0;
        bus.i_tx_valid = 1'b0;
        bus.i_tx_data = 8'h00;
        i_rst = 1'b1;
        repeat (3) @(negedge i_clk);
        checks++;
        if (outs() !== 16'h0008) begin
            errors++;
            $display("FAIL reset_outputs: got %04h, required 0008", outs());
        end
        i_rst = 1'b0;
        repeat (4) @(negedge i_clk);
        checks++;
        if (outs() !== 16'h0008) begin
            errors++;
            $display("FAIL idle_outputs: got %04h, required 0008", outs());
        end
        checks++;
        if (n_rx + n_und + n_abort != 0) begin
            errors++;
            $display("FAIL reset_pulses: got %0d, required 0", n_rx + n_und + n_abort);
        end
    endtask

    task automatic test_rx_two_bytes();
        n_rx = 0;
        n_abort = 0;
        exp_q.push_back({1'b1, 8'h9F});
        exp_q.push_back({1'b0, 8'h00});
        spi_frame(16, 16'h9F00, 1'b0, m);
        checks++;
        if (n_rx != 2) begin
            errors++;
            $display("FAIL rx_count: got %0d, required 2", n_rx);
        end
        checks++;
        if (exp_q.size() != 0 || n_abort != 0) begin
            errors++;
            $display("FAIL rx_pending: got %0d left/%0d aborts, required 0/0", exp_q.size(), n_abort);
        end
        checks++;
        if (bus.o_rx_data !== 8'h00 || bus.o_busy !== 1'b0) begin
            errors++;
            $display("FAIL rx_hold: got data=%02h busy=%0b, required 00/0", bus.o_rx_data, bus.o_busy);
        end
    endtask

    task automatic test_tx_preload();
        n_und = 0;
        n_rx = 0;
        tx_write(8'hA5);
        checks++;
        if (bus.o_tx_ready !== 1'b0) begin
            errors++;
            $display("FAIL tx_full: got ready=%0b, required 0", bus.o_tx_ready);
        end
        exp_q.push_back({1'b1, 8'h12});
        exp_q.push_back({1'b0, 8'h34});
        fork
            spi_frame(16, 16'h1234, 1'b0, m);
            begin
                for (int i = 0; i < 400 && bus.o_tx_ready !== 1'b1; i++) @(negedge i_clk);
                checks++;
                if (bus.o_tx_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL tx_ready_timeout: got ready=%0b, required 1", bus.o_tx_ready);
                end else begin
                    tx_write(8'h3C);
                end
            end
        join
        checks++;
        if (m !== 16'hA53C) begin
            errors++;
            $display("FAIL tx_miso: got %04h, required a53c", m);
        end
        checks++;
        if (n_und != 0 || n_rx != 2) begin
            errors++;
            $display("FAIL tx_pulses: got und=%0d rx=%0d, required 0/2", n_und, n_rx);
        end
    endtask

    task automatic test_underrun();
        n_und = 0;
        checks++;
        if (bus.o_tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL und_ready: got %0b, required 1", bus.o_tx_ready);
        end
        exp_q.push_back({1'b1, 8'hC3});
        spi_frame(8, 16'h00C3, 1'b0, m);
        checks++;
        if (m[7:0] !== 8'hFF) begin
            errors++;
            $display("FAIL und_miso: got %02h, required ff", m[7:0]);
        end
        checks++;
        if (n_und != 1) begin
            errors++;
            $display("FAIL und_count: got %0d, required 1", n_und);
        end
    endtask

    task automatic test_abort();
        n_rx = 0;
        n_abort = 0;
        spi_frame(5, 16'h0015, 1'b0, m);
        checks++;
        if (n_rx != 0 || n_abort != 1) begin
            errors++;
            $display("FAIL abort_pulses: got rx=%0d abort=%0d, required 0/1", n_rx, n_abort);
        end
        exp_q.push_back({1'b1, 8'h5A});
        spi_frame(8, 16'h005A, 1'b0, m);
        checks++;
        if (n_rx != 1 || n_abort != 1 || bus.o_rx_data !== 8'h5A) begin
            errors++;
            $display("FAIL after_abort: got rx=%0d abort=%0d data=%02h, required 1/1/5a", n_rx, n_abort, bus.o_rx_data);
        end
    endtask

    task automatic test_reset_mid();
        n_rx = 0;
        exp_q.push_back({1'b1, 8'hAB});
        spi_frame(12, 16'h0ABC, 1'b1, m);
        checks++;
        if (n_rx != 1 || bus.o_busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_frame: got rx=%0d busy=%0b, required 1/1", n_rx, bus.o_busy);
        end
        n_rx = 0;
        n_und = 0;
        n_abort = 0;
        i_rst = 1'b1;
        repeat (3) @(negedge i_clk);
        checks++;
        if (outs() !== 16'h0008) begin
            errors++;
            $display("FAIL midrst_outputs: got %04h, required 0008", outs());
        end
        bus.i_spi_clk = 1'b0;
        bus.i_cs = 1'b1;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        repeat (8) @(negedge i_clk);
        checks++;
        if (outs() !== 16'h0008 || n_rx + n_und + n_abort != 0) begin
            errors++;
            $display("FAIL midrst_release: got %04h pulses=%0d, required 0008/0", outs(), n_rx + n_und + n_abort);
        end
        exp_q.push_back({1'b1, 8'h03});
        spi_frame(8, 16'h0003, 1'b0, m);
        checks++;
        if (n_rx != 1 || bus.o_rx_data !== 8'h03 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL midrst_next: got rx=%0d data=%02h left=%0d, required 1/03/0", n_rx, bus.o_rx_data, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_rx_two_bytes();
        test_tx_preload();
        test_underrun();
        test_abort();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
